// File: rtl/dtc_stub_pattern_gen.sv
// dtc_stub_pattern_gen
// Generates per-channel stub test patterns in fixed-length event windows.
// The FSM runs IDLE -> RUN -> DRAIN -> IDLE. Each RUN window lasts EVT_LEN
// cycles. At the start of a window every channel latches a stub count. From
// the second cycle of the window, each channel then emits that many stubs
// under valid/ready handshaking.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   enable     - run request
//   nstub_cfg  - requested stubs per channel per event (clamped to NSTUB_MAX)
//   stub_data  - NCH words of DW bits, channel c at [c*DW +: DW]
//   stub_valid - per-channel data valid
//   stub_ready - per-channel consumer ready
//   stub_last  - per-channel final stub of the event
//   evt_start  - one-cycle pulse on the first cycle of each window
//   evt_num    - current event number, wraps 4095 -> 0
//   busy       - FSM not in IDLE
//   overflow   - sticky per-channel flag, set when stubs are dropped at window end
module dtc_stub_pattern_gen #(
  parameter int NCH       = 4,
  parameter int DW        = 36,
  parameter int NSTUB_MAX = 16,
  parameter int EVT_LEN   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        nstub_cfg,
  output logic [NCH*DW-1:0] stub_data,
  output logic [NCH-1:0]    stub_valid,
  input  logic [NCH-1:0]    stub_ready,
  output logic [NCH-1:0]    stub_last,
  output logic              evt_start,
  output logic [11:0]       evt_num,
  output logic              busy,
  output logic [NCH-1:0]    overflow
);

  localparam int            CW       = (EVT_LEN > 1) ? $clog2(EVT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EVT_LEN - 1);
  localparam logic [7:0]    NMAX     = 8'(NSTUB_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [11:0]   evt_num_reg;
  logic          evt_start_reg;
  logic          busy_reg;

  logic       win_first;
  logic       win_last;
  logic [7:0] cfg_n;

  assign win_first = (state_reg == RUN) && (cnt_reg == '0);
  assign win_last  = (state_reg == RUN) && (cnt_reg == CNT_LAST);
  assign cfg_n     = (nstub_cfg > NMAX) ? NMAX : nstub_cfg;

  // Control FSM. evt_start and busy are registered alongside the state so that
  // they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      evt_num_reg   <= '0;
      evt_start_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            evt_start_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        RUN: begin
          evt_start_reg <= 1'b0;
          if (cnt_reg == CNT_LAST) begin
            cnt_reg     <= '0;
            evt_num_reg <= evt_num_reg + 12'd1;
            // Back-to-back windows when still enabled; otherwise the
            // window that just ended is the last one.
            if (enable) evt_start_reg <= 1'b1;
            else        state_reg     <= DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign evt_start = evt_start_reg;
  assign evt_num   = evt_num_reg;
  assign busy      = busy_reg;

  // One independent emitter per channel. Valid is only ever set at the start
  // of a window and is cleared at the last window cycle. It is therefore
  // always low in IDLE and DRAIN.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [7:0]    n_reg;
      logic [7:0]    idx_reg;
      logic          valid_reg;
      logic          ovf_reg;
      logic          is_last;
      logic [DW-1:0] word;

      assign is_last = (idx_reg == n_reg - 8'd1);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          n_reg     <= '0;
          idx_reg   <= '0;
          valid_reg <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (win_last) begin
          // A final-stub transfer on this very cycle is not a drop.
          if (valid_reg && !(stub_ready[gi] && is_last)) ovf_reg <= 1'b1;
          valid_reg <= 1'b0;
        end else if (win_first) begin
          n_reg     <= cfg_n;
          idx_reg   <= '0;
          valid_reg <= (cfg_n != 8'd0);
        end else if (valid_reg && stub_ready[gi]) begin
          if (is_last) valid_reg <= 1'b0;
          else         idx_reg   <= idx_reg + 8'd1;
        end
      end

      always_comb begin
        word = '0;
        if (valid_reg) word[23:0] = {evt_num_reg, 4'(gi), idx_reg};
      end

      assign stub_data[gi*DW +: DW] = word;
      assign stub_valid[gi]         = valid_reg;
      assign stub_last[gi]          = valid_reg && is_last;
      assign overflow[gi]           = ovf_reg;
    end
  endgenerate

endmodule
